ps2_host_tx: RTL
================

# ps2_host_tx

Host-to-device PS/2 transmitter, the send side of the keyboard link whose receive side is `KeyboardDecoder1`. It accepts one command byte, such as 0xED (set LEDs) or 0xFF (reset), through a valid/ready handshake. It runs the PS/2 request-to-send sequence, shifts out data, odd parity and stop on device-generated clock edges, and checks the device ACK. It drives open-drain enables only; the top level builds `PS2_CLK`/`PS2_DATA` as `oe ? 1'b0 : 1'bz`.

## Interface
- `INHIBIT_CYCLES`, 12000: cycles the host holds CLK low before requesting (120 µs at 100 MHz).
- `REQ_CYCLES`, 16: cycles DATA and CLK are both held low before CLK is released.
- `TIMEOUT_CYCLES`, 2000000: maximum cycles between device clock falls (20 ms).
- `FILT_LEN`, 8: consecutive equal samples needed to accept a line change.
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset; synchronous and active-high.
- `tx_data`  in  8  command byte.
- `tx_valid`  in  1  request; a transfer is accepted when `tx_valid && tx_ready`.
- `tx_ready`  out  1  high only in IDLE.
- `busy`  out  1  high from acceptance until return to IDLE.
- `done`  out  1  one-cycle pulse when a transfer completes (ACK or NACK).
- `ack_ok`  out  1  valid with `done`: 1 = device ACKed; held until the next acceptance.
- `error`  out  1  one-cycle pulse on timeout.
- `ps2_clk_in`, `ps2_data_in`  in  1  raw pad levels.
- `ps2_clk_oe`, `ps2_data_oe`  out  1  1 = pull the line low.
- `rx_inhibit`  out  1  equals `busy`; `KeyboardDecoder1` discards frames while it is high.

## Operation
- Input conditioning: each pad input passes through a 2-FF synchronizer, then the `FILT_LEN` stable filter. `clk_fall` is a one-cycle pulse when the filtered clock goes 1→0.
- Frame shift register: 10 bits `{1'b1, ~^tx_data, tx_data}`, latched on acceptance and shifted LSB first.
- IDLE: both oe = 0, `tx_ready` = 1. On acceptance: latch the frame, set `busy`, clear the counter, clear `ack_ok`, go to INHIBIT.
- INHIBIT: `clk_oe` = 1, `data_oe` = 0, for `INHIBIT_CYCLES`; then go to REQ. Any device frame in progress is aborted, which the protocol allows.
- REQ: `clk_oe` = 1, `data_oe` = 1 (start bit), for `REQ_CYCLES`; then `clk_oe` = 0 and go to SEND with bit index 0.
- SEND: on each `clk_fall`, `data_oe` ← ~frame[0], then shift and increment the index. After the 10th fall (stop bit: `data_oe` = 0) go to ACK.
- ACK: on the next `clk_fall`, sample the filtered DATA. `ack_ok` ← ~data. Go to WAIT_REL.
- WAIT_REL: wait until filtered CLK and DATA are both 1. Then pulse `done`, clear `busy`, go to IDLE.
- Timeout: in SEND, ACK and WAIT_REL, the counter clears on every `clk_fall`. Reaching `TIMEOUT_CYCLES` forces both oe = 0, pulses `error`, clears `busy`, goes to IDLE, and leaves `ack_ok` = 0.
- `tx_valid` while `busy` is ignored; no queueing.
- Counter: a single 21-bit cycle counter is shared by INHIBIT, REQ and timeout, and clears on every state change.

## Timing
- Reset values: state IDLE, `tx_ready` = 1, all other outputs 0, filter outputs 1 (lines idle high), shift register 0.
- `rst` mid-transfer: both oe are 0 on the next cycle, with no `done` or `error` pulse.
- Acceptance to `clk_oe` high: 1 cycle (registered).
- CLK low time: exactly `INHIBIT_CYCLES` + `REQ_CYCLES`. DATA goes low exactly `INHIBIT_CYCLES` after CLK.
- Pad falling edge to `data_oe` update: exactly `FILT_LEN` + 3 cycles (2 sync + `FILT_LEN` filter + 1 register).
- `clk_fall` and the timeout limit in the same cycle: `clk_fall` wins.
- `done` and `error` are mutually exclusive and each lasts exactly one cycle.
- `tx_ready` returns the cycle after `done` or `error`.

## Structure
- Shared package `ps2_pkg`: state enum (IDLE, INHIBIT, REQ, SEND, ACK, WAIT_REL), the command constants `CMD_SET_LED` = 8'hED, `CMD_ECHO` = 8'hEE, `CMD_RESET` = 8'hFF, and `ACK_BYTE` = 8'hFA.
- Sub-module `ps2_sync_filter` (parameter `FILT_LEN`, outputs level and fall pulse), instantiated twice. The receiver can reuse it.

## Test plan
- Send 0xED with a device model ACKing: line bits after start are 1,0,1,1,0,1,1,1, parity 1, stop 1. Then `done` = 1 with `ack_ok` = 1, and `tx_ready` = 1 the following cycle.
- Send 0x07: parity bit = 0. Send 0x00: parity bit = 1. Each ends with `done`, `ack_ok` = 1.
- Device holds DATA high on the 11th clock (NACK): `done` pulses with `ack_ok` = 0 and `error` = 0.
- Device never clocks: `error` pulses exactly `INHIBIT_CYCLES` + `REQ_CYCLES` + `TIMEOUT_CYCLES` (+1 acceptance) cycles after acceptance, both oe are 0, and no `done`.
- Assert `rst` during SEND bit 4: both oe are 0 next cycle, `tx_ready` = 1, no pulses. A following 0xFF transfer completes normally.
- Hold `tx_valid` high with 0x11 during the 0xED transfer: only 0xED is sent. 3-cycle glitches on CLK never produce a `clk_fall` and do not shift the bit index.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 host states and keyboard command constants
package ps2_pkg;
    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_REL} ps2_state_e;
    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ECHO = 8'hEE;
    localparam logic [7:0] CMD_RESET = 8'hFF;
    localparam logic [7:0] ACK_BYTE = 8'hFA;
endpackage

// File: rtl/ps2_sync_filter.sv
// ps2_sync_filter: 2-FF synchronizer plus stability filter for one PS/2 pad, with a fall pulse
module ps2_sync_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic level,
    output logic fall
);
    localparam int CW = $clog2(FILT_LEN + 1);
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    logic diff, flip;
    assign diff = sync[1] != level;
    assign flip = diff && cnt == CW'(FILT_LEN - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 2'b11;
            cnt <= '0;
            level <= 1'b1;
            fall <= 1'b0;
        end else begin
            sync <= {sync[0], pad};
            cnt <= (diff && !flip) ? cnt + CW'(1) : '0;
            level <= flip ? sync[1] : level;
            fall <= flip && level;
        end
    end
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with ACK check and clock timeout
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int REQ_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILT_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       rx_inhibit
);
    ps2_state_e state, state_n;
    logic [20:0] cnt;
    logic [9:0] sh;
    logic [3:0] idx;
    logic drive_data, accept, watch, rel, tout;
    logic clk_lvl, clk_fall, data_lvl, data_fall_unused;
    ps2_sync_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
        .clk(clk), .rst(rst), .pad(ps2_clk_in), .level(clk_lvl), .fall(clk_fall)
    );
    ps2_sync_filter #(.FILT_LEN(FILT_LEN)) u_data_filt (
        .clk(clk), .rst(rst), .pad(ps2_data_in), .level(data_lvl), .fall(data_fall_unused)
    );
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end
    // A device clock edge always beats the timeout limit landing in the same cycle
    always_comb begin
        state_n = state;
        accept = state == IDLE && tx_valid;
        watch = state == SEND || state == ACK || state == WAIT_REL;
        rel = state == WAIT_REL && clk_lvl && data_lvl;
        tout = watch && !clk_fall && !rel && cnt == 21'(TIMEOUT_CYCLES);
        case (state)
            IDLE:     state_n = tx_valid ? INHIBIT : IDLE;
            INHIBIT:  state_n = cnt == 21'(INHIBIT_CYCLES - 1) ? REQ : INHIBIT;
            REQ:      state_n = cnt == 21'(REQ_CYCLES - 1) ? SEND : REQ;
            SEND:     state_n = (clk_fall && idx == 4'd9) ? ACK : SEND;
            ACK:      state_n = clk_fall ? WAIT_REL : ACK;
            WAIT_REL: state_n = rel ? IDLE : WAIT_REL;
            default:  state_n = IDLE;
        endcase
        if (tout)
            state_n = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            sh <= '0;
            idx <= '0;
            drive_data <= 1'b0;
            ack_ok <= 1'b0;
        end else begin
            cnt <= (state_n != state || (watch && clk_fall) || state == IDLE) ? '0 : cnt + 21'd1;
            if (accept) begin
                sh <= {1'b1, ~^tx_data, tx_data};
                ack_ok <= 1'b0;
            end
            if (state == REQ) begin
                drive_data <= 1'b1;
                idx <= '0;
            end
            // Frame bit 1 means release the line, so the enable is its inverse
            if (state == SEND && clk_fall) begin
                drive_data <= ~sh[0];
                sh <= sh >> 1;
                idx <= idx + 4'd1;
            end
            if (state == ACK && clk_fall)
                ack_ok <= ~data_lvl;
            if (tout)
                ack_ok <= 1'b0;
        end
    end
    assign tx_ready = state == IDLE;
    assign busy = !tx_ready;
    assign rx_inhibit = busy;
    assign done = rel;
    assign error = tout;
    assign ps2_clk_oe = state == INHIBIT || state == REQ;
    assign ps2_data_oe = state == REQ || (state == SEND && drive_data);
endmodule
